// File: rtl/ace_snoop_sequencer.sv
// ACE snoop sequencer: AC request -> dcache lookup -> CR response -> optional CD line burst.
// Latency: AC accept to lk_req_o 1 cycle, lk_rvalid_i to cr_valid_o 1 cycle, CR to first CD beat 1 cycle.
// Backpressure: one snoop in flight, ac_ready_o low outside IDLE; CR/CD hold until ready. ACE_SNOOP_PERF_CNT_EN adds counters.
module ace_snoop_sequencer #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineBeats = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ac_valid_i,
    output logic                           ac_ready_o,
    input  logic [AddrWidth-1:0]           ac_addr_i,
    input  logic [3:0]                     ac_snoop_i,
    output logic                           cr_valid_o,
    input  logic                           cr_ready_i,
    output logic [4:0]                     cr_resp_o,
    output logic                           cd_valid_o,
    input  logic                           cd_ready_i,
    output logic [DataWidth-1:0]           cd_data_o,
    output logic                           cd_last_o,
    output logic                           lk_req_o,
    input  logic                           lk_gnt_i,
    output logic [AddrWidth-1:0]           lk_addr_o,
    output logic                           lk_inval_o,
    output logic                           lk_share_o,
    input  logic                           lk_rvalid_i,
    input  logic                           lk_hit_i,
    input  logic                           lk_dirty_i,
    input  logic                           lk_shared_i,
    input  logic [LineBeats*DataWidth-1:0] lk_line_i
`ifdef ACE_SNOOP_PERF_CNT_EN
    ,
    output logic [31:0]                    snoop_cnt_o,
    output logic [31:0]                    snoop_hit_cnt_o
`endif
);
    localparam int LineBytes = LineBeats * DataWidth / 8;
    localparam int BeatW     = (LineBeats > 1) ? $clog2(LineBeats) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RSP, SEND_CR, SEND_CD} state_t;

    state_t                              state, state_d;
    logic [AddrWidth-1:0]                addr_q;
    logic [3:0]                          snoop_q;
    logic                                inval_q, share_q, rdy_q;
    logic [4:0]                          resp_q, resp_new;
    logic [LineBeats-1:0][DataWidth-1:0] line_q;
    logic [BeatW-1:0]                    beat_q;
    logic                                ac_hs, last_beat;
    logic                                code_ok, code_inval, code_share;
    logic                                is_read, is_mkinv, is_ronce, is_rclean;
    logic                                dt, pd;

    always_comb begin
        code_ok    = 1'b1;
        code_inval = 1'b0;
        code_share = 1'b0;
        case (ac_snoop_i)
            4'b0000:                   ;
            4'b0111, 4'b1001, 4'b1101: code_inval = 1'b1;
            4'b0001, 4'b0010, 4'b0011,
            4'b1000:                   code_share = 1'b1;
            default:                   code_ok    = 1'b0;
        endcase
    end

    assign is_read   = (snoop_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111});
    assign is_mkinv  = (snoop_q == 4'b1101);
    assign is_ronce  = (snoop_q == 4'b0000);
    assign is_rclean = (snoop_q == 4'b0010);

    // A miss forces every response bit to zero through the hit term.
    assign dt       = lk_hit_i & ~is_mkinv & (is_read | lk_dirty_i);
    assign pd       = dt & lk_dirty_i & ~is_ronce & ~is_rclean;
    assign resp_new = {lk_hit_i & ~lk_shared_i, lk_hit_i & ~inval_q, pd, 1'b0, dt};

    assign ac_hs     = ac_valid_i & rdy_q & (state == IDLE);
    assign last_beat = (beat_q == BeatW'(LineBeats - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (ac_hs)       state_d = code_ok ? LOOKUP : SEND_CR;
            LOOKUP:   if (lk_gnt_i)    state_d = WAIT_RSP;
            WAIT_RSP: if (lk_rvalid_i) state_d = SEND_CR;
            SEND_CR:  if (cr_ready_i)  state_d = resp_q[0] ? SEND_CD : IDLE;
            SEND_CD:  if (cd_ready_i && last_beat) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            snoop_q <= '0;
            inval_q <= 1'b0;
            share_q <= 1'b0;
            resp_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            // Ready is registered so it stays low while reset is asserted.
            rdy_q <= (state_d == IDLE);
            if (ac_hs) begin
                addr_q  <= ac_addr_i & ~AddrWidth'(LineBytes - 1);
                snoop_q <= ac_snoop_i;
                inval_q <= code_inval;
                share_q <= code_share;
                resp_q  <= code_ok ? 5'b00000 : 5'b00010;
            end
            if (state == WAIT_RSP && lk_rvalid_i) begin
                resp_q <= resp_new;
                line_q <= lk_line_i;
            end
            if (state == SEND_CR && cr_ready_i)
                beat_q <= '0;
            else if (state == SEND_CD && cd_ready_i && !last_beat)
                beat_q <= beat_q + BeatW'(1);
        end
    end

    assign ac_ready_o = rdy_q;
    assign lk_req_o   = (state == LOOKUP);
    assign lk_addr_o  = addr_q;
    assign lk_inval_o = inval_q;
    assign lk_share_o = share_q;
    assign cr_valid_o = (state == SEND_CR);
    assign cr_resp_o  = cr_valid_o ? resp_q : 5'b00000;
    assign cd_valid_o = (state == SEND_CD);
    assign cd_data_o  = line_q[beat_q];
    assign cd_last_o  = cd_valid_o & last_beat;

`ifdef ACE_SNOOP_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snoop_cnt_o     <= '0;
            snoop_hit_cnt_o <= '0;
        end else begin
            if (ac_hs && snoop_cnt_o != 32'hFFFF_FFFF)
                snoop_cnt_o <= snoop_cnt_o + 32'd1;
            if (state == WAIT_RSP && lk_rvalid_i && lk_hit_i && snoop_hit_cnt_o != 32'hFFFF_FFFF)
                snoop_hit_cnt_o <= snoop_hit_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Directed bench for ace_snoop_sequencer: each snoop vector carries hand-computed lookup fields,
// response code and data beats; also covers CD stall backpressure and reset mid-burst.
module tb_ace_snoop_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         ac_valid, ac_ready;
    logic [63:0]  ac_addr;
    logic [3:0]   ac_snoop;
    logic         cr_valid, cr_ready;
    logic [4:0]   cr_resp;
    logic         cd_valid, cd_ready, cd_last;
    logic [63:0]  cd_data;
    logic         lk_req, lk_gnt, lk_inval, lk_share;
    logic [63:0]  lk_addr;
    logic         lk_rvalid, lk_hit, lk_dirty, lk_shared;
    logic [127:0] lk_line;
`ifdef ACE_SNOOP_PERF_CNT_EN
    logic [31:0]  snoop_cnt, snoop_hit_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ace_snoop_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
        .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
        .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
        .lk_req_o(lk_req), .lk_gnt_i(lk_gnt), .lk_addr_o(lk_addr), .lk_inval_o(lk_inval),
        .lk_share_o(lk_share), .lk_rvalid_i(lk_rvalid), .lk_hit_i(lk_hit), .lk_dirty_i(lk_dirty),
        .lk_shared_i(lk_shared), .lk_line_i(lk_line)
`ifdef ACE_SNOOP_PERF_CNT_EN
        , .snoop_cnt_o(snoop_cnt), .snoop_hit_cnt_o(snoop_hit_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ac_ready"}, ac_ready, 0);
        check({tag, "_lk_req"},   lk_req,   0);
        check({tag, "_cr_valid"}, cr_valid, 0);
        check({tag, "_cr_resp"},  cr_resp,  0);
        check({tag, "_cd_valid"}, cd_valid, 0);
        check({tag, "_cd_last"},  cd_last,  0);
    endtask

    // Drives one snoop end to end; error codes (resp bit 1) skip the lookup handshake.
    task automatic run_snoop(input string tag, input logic [63:0] addr, input logic [3:0] op,
                             input logic hit, input logic dirty, input logic shared,
                             input logic [127:0] line, input logic [63:0] exp_addr,
                             input logic exp_inval, input logic exp_share,
                             input logic [4:0] exp_resp, input bit stall, input bit abort);
        int waitc;
        logic [63:0] beat_exp;
        ac_addr  = addr;
        ac_snoop = op;
        ac_valid = 1'b1;
        waitc = 0;
        while (!ac_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_ac_ready"}, ac_ready, 1);
        @(posedge clk); #1;
        ac_valid = 1'b0;
        if (exp_resp[1] == 1'b0) begin
            check({tag, "_lk_req"},   lk_req,   1);
            check({tag, "_lk_addr"},  lk_addr,  exp_addr);
            check({tag, "_lk_inval"}, lk_inval, exp_inval);
            check({tag, "_lk_share"}, lk_share, exp_share);
            @(posedge clk); #1;
            check({tag, "_lk_req_hold"},  lk_req,  1);
            check({tag, "_lk_addr_hold"}, lk_addr, exp_addr);
            lk_gnt = 1'b1;
            @(posedge clk); #1;
            lk_gnt = 1'b0;
            check({tag, "_lk_req_drop"}, lk_req, 0);
            @(posedge clk); #1;
            check({tag, "_cr_early"}, cr_valid, 0);
            lk_rvalid = 1'b1; lk_hit = hit; lk_dirty = dirty; lk_shared = shared; lk_line = line;
            @(posedge clk); #1;
            lk_rvalid = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b0; lk_shared = 1'b0;
        end else begin
            check({tag, "_lk_req_none"}, lk_req, 0);
        end
        check({tag, "_cr_valid"}, cr_valid, 1);
        check({tag, "_cr_resp"},  cr_resp,  exp_resp);
        check({tag, "_ac_busy"},  ac_ready, 0);
        cr_ready = 1'b1;
        @(posedge clk); #1;
        cr_ready = 1'b0;
        check({tag, "_cr_drop"}, cr_valid, 0);
        if (exp_resp[0]) begin
            for (int b = 0; b < 2; b++) begin
                beat_exp = (b == 0) ? line[63:0] : line[127:64];
                check({tag, "_cd_valid"}, cd_valid, 1);
                check({tag, "_cd_data"},  cd_data,  beat_exp);
                check({tag, "_cd_last"},  cd_last,  (b == 1));
                if (b == 0 && abort) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle_outputs({tag, "_abort"});
                    return;
                end
                if (b == 0 && stall) begin
                    ac_valid = 1'b1;
                    ac_addr  = 64'h0000_0000_0000_0F00;
                    ac_snoop = 4'b0001;
                    repeat (5) begin
                        @(posedge clk); #1;
                        check({tag, "_stall_valid"}, cd_valid, 1);
                        check({tag, "_stall_data"},  cd_data,  beat_exp);
                        check({tag, "_stall_ac"},    ac_ready, 0);
                    end
                    ac_valid = 1'b0;
                end
                cd_ready = 1'b1;
                @(posedge clk); #1;
                cd_ready = 1'b0;
            end
        end
        check({tag, "_cd_done"}, cd_valid, 0);
        check({tag, "_idle"},    ac_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ac_valid = 1'b0; ac_addr = '0; ac_snoop = '0;
        cr_ready = 1'b0; cd_ready = 1'b0;
        lk_gnt = 1'b0; lk_rvalid = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b0; lk_shared = 1'b0;
        lk_line = '0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_ready", ac_ready, 1);

        run_snoop("rd_shared", 64'h0000_0000_8000_0048, 4'b0001, 1, 0, 0,
                  128'h1111_1111_1111_1111_2222_2222_2222_2222,
                  64'h0000_0000_8000_0040, 0, 1, 5'b11001, 0, 0);
        run_snoop("rd_unique", 64'h1234_5678_9ABC_DEF7, 4'b0111, 1, 1, 1,
                  128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB,
                  64'h1234_5678_9ABC_DEF0, 1, 0, 5'b00101, 1, 0);
        run_snoop("clean_inv_miss", 64'h0000_0000_0000_1000, 4'b1001, 0, 0, 0,
                  128'h5555_5555_5555_5555_6666_6666_6666_6666,
                  64'h0000_0000_0000_1000, 1, 0, 5'b00000, 0, 0);
        run_snoop("bad_op", 64'h0000_0000_0000_2000, 4'b1111, 0, 0, 0,
                  128'h0, 64'h0, 0, 0, 5'b00010, 0, 0);
        run_snoop("clean_shared", 64'h0000_0000_0000_002F, 4'b1000, 1, 1, 0,
                  128'hCCCC_0000_CCCC_0001_DDDD_0000_DDDD_0002,
                  64'h0000_0000_0000_0020, 0, 1, 5'b11101, 0, 0);
        run_snoop("rd_once", 64'h0000_0000_0000_0040, 4'b0000, 1, 0, 1,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  64'h0000_0000_0000_0040, 0, 0, 5'b01001, 0, 0);
        run_snoop("make_inv", 64'h0000_0000_0000_07FF, 4'b1101, 1, 1, 0,
                  128'hDEAD_BEEF_DEAD_BEEF_CAFE_F00D_CAFE_F00D,
                  64'h0000_0000_0000_07F0, 1, 0, 5'b10000, 0, 0);
`ifdef ACE_SNOOP_PERF_CNT_EN
        check("perf_snoops", snoop_cnt, 7);
        check("perf_hits",   snoop_hit_cnt, 5);
`endif
        run_snoop("abort", 64'h0000_0000_0000_0300, 4'b0010, 1, 1, 0,
                  128'h7777_7777_7777_7777_8888_8888_8888_8888,
                  64'h0000_0000_0000_0300, 0, 1, 5'b11001, 0, 1);
        @(posedge clk); #1;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
`ifdef ACE_SNOOP_PERF_CNT_EN
        check("perf_snoops_rst", snoop_cnt, 0);
        check("perf_hits_rst",   snoop_hit_cnt, 0);
`endif
        run_snoop("rd_nsd_after_rst", 64'h0000_0000_0000_0055, 4'b0011, 1, 1, 0,
                  128'h9999_9999_9999_9999_4444_4444_4444_4444,
                  64'h0000_0000_0000_0050, 0, 1, 5'b11101, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ace_snoop_sequencer.md
Name: ace_snoop_sequencer

Overview:
- Sequences one ACE snoop transaction at a time between the interconnect snoop channels and the data cache snoop lookup port.
- AC handshake -> cache lookup/state-update request -> CR response -> optional CD data burst of one cache line.
- Sits between the ACE port of the core and the dcache controller; accepts snoop-request fields and drives snoop-response fields.

Parameters:
- AddrWidth, 64, AC address width
- DataWidth, 64, CD beat width
- LineBeats, 2, CD beats per cache line; line = LineBeats*DataWidth bits

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ac_valid_i  in  1  snoop address valid
- ac_ready_o  out  1  snoop address accepted
- ac_addr_i  in  AddrWidth  snoop address
- ac_snoop_i  in  4  ACSNOOP code
- cr_valid_o  out  1  snoop response valid
- cr_ready_i  in  1  snoop response accepted
- cr_resp_o  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cd_valid_o  out  1  snoop data valid
- cd_ready_i  in  1  snoop data accepted
- cd_data_o  out  DataWidth  snoop data beat
- cd_last_o  out  1  last beat
- lk_req_o  out  1  cache lookup request
- lk_gnt_i  in  1  cache lookup granted
- lk_addr_o  out  AddrWidth  line-aligned lookup address
- lk_inval_o  out  1  invalidate line on hit
- lk_share_o  out  1  downgrade line to shared-clean on hit
- lk_rvalid_i  in  1  lookup result valid (>=1 cycle after gnt)
- lk_hit_i  in  1  line present
- lk_dirty_i  in  1  line dirty
- lk_shared_i  in  1  line in shared state
- lk_line_i  in  LineBeats*DataWidth  line data, beat 0 in LSBs

Behaviour:
- Clock clk_i; reset rst_ni asynchronous active-low. Reset: state IDLE, all outputs 0, beat counter 0, buffers 0.
- FSM: IDLE -> LOOKUP -> WAIT_RSP -> SEND_CR -> [SEND_CD] -> IDLE.
- IDLE: ac_ready_o=1. On ac_valid_i: latch addr (low log2(LineBytes) bits zeroed) and snoop; go LOOKUP.
- LOOKUP: lk_req_o=1 with lk_addr_o/lk_inval_o/lk_share_o stable until lk_gnt_i; then WAIT_RSP.
- Snoop decode:
  - Invalidate: ReadUnique 0111, CleanInvalid 1001, MakeInvalid 1101.
  - Share: ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011.
  - CleanShared 1000: lk_share_o=1.
  - ReadOnce 0000: neither.
  - Any other code: no lookup (skip to SEND_CR), cr_resp_o=5'b00010 (Error).
- WAIT_RSP: on lk_rvalid_i, latch hit/dirty/shared/line; go SEND_CR. Response fields, all 0 on miss:
  - DataTransfer = hit & !MakeInvalid & (read-type | dirty)
  - PassDirty = DataTransfer & dirty & !ReadOnce & !ReadClean
  - IsShared = hit & !invalidate-type
  - WasUnique = hit & !shared
- SEND_CR: cr_valid_o=1, cr_resp_o held until cr_ready_i. If DataTransfer, go SEND_CD with beat=0; else IDLE.
- SEND_CD:
  - cd_valid_o=1; cd_data_o=beat slice; cd_last_o=(beat==LineBeats-1).
  - Each cd_ready_i advances beat. Last-beat handshake -> IDLE.
  - Counter width clog2(LineBeats); no wrap beyond last.
- Latency: ac accept -> lk_req_o next cycle; lk_rvalid_i -> cr_valid_o next cycle; CR handshake -> first cd_valid_o next cycle.
- ac_valid_i outside IDLE is back-pressured (ac_ready_o=0); strictly one outstanding snoop.
- Deasserting rst_ni mid-transaction aborts it; all valids drop asynchronously.

Optional Feature:
- Macro ACE_SNOOP_PERF_CNT_EN.
- Defined: adds outputs snoop_cnt_o[31:0] and snoop_hit_cnt_o[31:0]; both increment on AC handshake / lookup hit respectively, saturate at 32'hFFFFFFFF, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ReadShared 0001 addr 0x8000_0048, hit clean unique -> lk_addr_o 0x8000_0040, lk_share_o=1, cr_resp_o 5'b11001, two CD beats, cd_last_o on beat 1.
- ReadUnique 0111, hit dirty shared -> lk_inval_o=1, cr_resp_o 5'b00101, line 128'hA..B sent as beat0=64'hB.., beat1=64'hA...
- CleanInvalid 1001 miss -> cr_resp_o 5'b00000, no cd_valid_o, back to IDLE.
- Opcode 1111 -> no lk_req_o, cr_resp_o 5'b00010.
- cd_ready_i held low 5 cycles on beat 0 -> data/valid stable; ac_valid_i during it sees ac_ready_o=0.
- rst_ni asserted in SEND_CD -> all outputs 0 immediately; subsequent snoop completes normally; with ACE_SNOOP_PERF_CNT_EN, counters read 0 after reset.
